// File: rtl/uart_prog_loader.sv
// -----------------------------------------------------------------------------
// uart_prog_loader
//
// Parses framed program images arriving from a UART receiver and streams the
// payload into memory through a simple write port. While a load is in
// progress the CPU is held stopped. Each complete frame is answered with an
// ACK (0x06) or NAK (0x15) byte through the UART transmitter.
//
// Frame format: 0xA5, ADDR, LEN, LEN payload bytes, CSUM
//   LEN = 0 means 256 payload bytes.
//   CSUM = (ADDR + LEN + sum of payload) mod 256. The header is excluded.
//
// Parameters:
//   ADDR_W          memory address width; the write pointer wraps mod 2^ADDR_W
//   TIMEOUT_CYCLES  inter-byte timeout in clk cycles (>= 2)
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   reset      asynchronous, active-high reset
//   rx_data    received byte                     rx_valid  one-cycle strobe
//   tx_data    response byte                     tx_start  one-cycle strobe
//   tx_busy    transmitter busy, tx_start only issued while low
//   mem_addr   write address                     mem_wdata write data
//   mem_we     one-cycle write strobe
//   cpu_hold   high while the CPU must stay stopped
//   load_done  one-cycle pulse on a successful frame
//   err        sticky error flag (bad checksum or timeout)
// -----------------------------------------------------------------------------
module uart_prog_loader #(
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 2700000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              err
);

    localparam int                TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]        HDR_BYTE = 8'hA5;
    localparam logic [7:0]        ACK_BYTE = 8'h06;
    localparam logic [7:0]        NAK_BYTE = 8'h15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_RESP
    } state_t;

    // Registered state and its next-state values.
    state_t              state,       state_d;
    logic [ADDR_W-1:0]   ptr,         ptr_d;       // next write address
    logic [8:0]          cnt,         cnt_d;       // payload bytes still to come
    logic [7:0]          sum,         sum_d;       // running checksum
    logic [TMO_W-1:0]    tmo,         tmo_d;       // cycles since last byte
    logic                ok,          ok_d;        // checksum matched
    logic [7:0]          tx_data_d;
    logic                tx_start_d;
    logic [ADDR_W-1:0]   mem_addr_d;
    logic [7:0]          mem_wdata_d;
    logic                mem_we_d;
    logic                cpu_hold_d;
    logic                load_done_d;
    logic                err_d;

    logic                in_frame;

    // The inter-byte timeout only runs while a frame is being received;
    // RESP waits on the transmitter and is not subject to it.
    assign in_frame = (state inside {S_ADDR, S_LEN, S_DATA, S_CSUM});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            ptr       <= '0;
            cnt       <= '0;
            sum       <= '0;
            tmo       <= '0;
            ok        <= 1'b0;
            tx_data   <= '0;
            tx_start  <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            cpu_hold  <= 1'b0;
            load_done <= 1'b0;
            err       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            state     <= state_d;
            ptr       <= ptr_d;
            cnt       <= cnt_d;
            sum       <= sum_d;
            tmo       <= tmo_d;
            ok        <= ok_d;
            tx_data   <= tx_data_d;
            tx_start  <= tx_start_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            mem_we    <= mem_we_d;
            cpu_hold  <= cpu_hold_d;
            load_done <= load_done_d;
            err       <= err_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d     = state;
        ptr_d       = ptr;
        cnt_d       = cnt;
        sum_d       = sum;
        ok_d        = ok;
        tx_data_d   = tx_data;
        tx_start_d  = 1'b0;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        mem_we_d    = 1'b0;
        cpu_hold_d  = cpu_hold;
        load_done_d = 1'b0;
        err_d       = err;

        if (in_frame && !rx_valid) begin
            tmo_d = tmo + TMO_W'(1);
        end else begin
            tmo_d = '0;
        end

        unique case (state)
            S_IDLE: begin
                if (rx_valid && rx_data == HDR_BYTE) begin
                    state_d    = S_ADDR;
                    cpu_hold_d = 1'b1;
                    err_d      = 1'b0;
                    sum_d      = '0;
                end
            end

            S_ADDR: begin
                if (rx_valid) begin
                    ptr_d   = ADDR_W'(rx_data);
                    sum_d   = sum + rx_data;
                    state_d = S_LEN;
                end
            end

            S_LEN: begin
                if (rx_valid) begin
                    cnt_d   = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                    sum_d   = sum + rx_data;
                    state_d = S_DATA;
                end
            end

            S_DATA: begin
                if (rx_valid) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = ptr;
                    mem_wdata_d = rx_data;
                    ptr_d       = ptr + ADDR_W'(1);
                    cnt_d       = cnt - 9'd1;
                    sum_d       = sum + rx_data;
                    if (cnt == 9'd1) begin
                        state_d = S_CSUM;
                    end
                end
            end

            S_CSUM: begin
                if (rx_valid) begin
                    if (rx_data == sum) begin
                        tx_data_d = ACK_BYTE;
                        ok_d      = 1'b1;
                    end else begin
                        tx_data_d = NAK_BYTE;
                        ok_d      = 1'b0;
                        err_d     = 1'b1;
                    end
                    state_d = S_RESP;
                end
            end

            S_RESP: begin
                // Received bytes are dropped here; the frame is already over.
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    if (ok) begin
                        load_done_d = 1'b1;
                        cpu_hold_d  = 1'b0;
                    end
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Silence for too long abandons the frame without a response. Writes
        // already made stay in memory and cpu_hold stays up, so the partial
        // image can never run. A byte in the expiry cycle keeps the frame.
        if (in_frame && !rx_valid && tmo == TMO_LAST) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_uart_prog_loader
//
// Self-checking bench for uart_prog_loader: a table of fixed frames with
// hand-computed responses, hand-written timing sequences for the multi-cycle
// corner cases, and random frames checked against a checksum/write model.
// -----------------------------------------------------------------------------
module tb_uart_prog_loader;

    localparam int ADDR_W = 8;
    localparam int TMO    = 50;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              tx_busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic              cpu_hold;
    logic              load_done;
    logic              err;

    always #5 clk = ~clk;

    uart_prog_loader #(
        .ADDR_W         (ADDR_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .err       (err)
    );

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;

    logic [15:0] wq[$];     // observed writes {addr, data}
    logic [7:0]  txq[$];    // observed response bytes
    logic [7:0]  pl_q[$];   // payload of the frame being sent

    typedef struct packed {
        logic [7:0]      addr;
        logic [7:0]      len;
        logic [3:0][7:0] d;        // d[0] is the first payload byte
        logic [7:0]      csum;
        logic [7:0]      exp_resp;
        logic            exp_err;
        logic            exp_hold;
        logic            exp_done;
    } vec_t;

    vec_t tbl[7];

    // Observe registered outputs well after the rising edge.
    always @(posedge clk) begin
        #2;
        if (mem_we)    wq.push_back({mem_addr, mem_wdata});
        if (tx_start)  txq.push_back(tx_data);
        if (load_done) done_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic gap(input int gap_max);
        idle(int'($urandom_range(0, gap_max)));
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, " tx_data"},   32'(tx_data),   32'h0);
        check({name, " tx_start"},  32'(tx_start),  32'h0);
        check({name, " mem_addr"},  32'(mem_addr),  32'h0);
        check({name, " mem_wdata"}, 32'(mem_wdata), 32'h0);
        check({name, " mem_we"},    32'(mem_we),    32'h0);
        check({name, " cpu_hold"},  32'(cpu_hold),  32'h0);
        check({name, " load_done"}, 32'(load_done), 32'h0);
        check({name, " err"},       32'(err),       32'h0);
    endtask

    // Reference checksum: plain sum of address, length and payload.
    function automatic logic [7:0] model_sum(input logic [7:0] addr, input logic [7:0] len);
        int s;
        s = int'(addr) + int'(len);
        foreach (pl_q[i]) s += int'(pl_q[i]);
        return 8'(s);
    endfunction

    task automatic wait_resp(input string name, output logic [7:0] r);
        int k;
        k = 0;
        while (txq.size() == 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (txq.size() == 0) begin
            check({name, " resp_wait"}, 32'h0, 32'h1);
            r = 8'hxx;
        end else begin
            r = txq.pop_front();
        end
    endtask

    // Sends a whole frame with payload pl_q and checks response, flags and
    // every memory write against the expectations given.
    task automatic run_frame(input string name, input logic [7:0] addr, input logic [7:0] len,
                             input logic [7:0] csum, input int gap_max,
                             input logic [7:0] exp_resp, input logic exp_err,
                             input logic exp_hold, input int exp_done);
        logic [7:0] r;
        logic [7:0] wa;
        int         d0;
        wq.delete();
        txq.delete();
        d0 = done_cnt;
        drive(8'hA5);
        gap(gap_max);
        drive(addr);
        gap(gap_max);
        drive(len);
        foreach (pl_q[i]) begin
            gap(gap_max);
            drive(pl_q[i]);
        end
        gap(gap_max);
        drive(csum);
        wait_resp(name, r);
        idle(2);
        check({name, " resp"},     32'(r),               32'(exp_resp));
        check({name, " extra_tx"}, 32'(txq.size()),      32'h0);
        check({name, " err"},      32'(err),             32'(exp_err));
        check({name, " cpu_hold"}, 32'(cpu_hold),        32'(exp_hold));
        check({name, " load_done"}, 32'(done_cnt - d0),  32'(exp_done));
        check({name, " nwrites"},  32'(wq.size()),       32'(pl_q.size()));
        for (int i = 0; i < pl_q.size() && i < wq.size(); i++) begin
            wa = addr + 8'(i);
            check($sformatf("%s wr%0d", name, i), 32'(wq[i]), 32'({wa, pl_q[i]}));
        end
    endtask

    function automatic vec_t mk(input logic [7:0] a, input logic [7:0] l, input logic [31:0] d,
                                input logic [7:0] c, input logic [7:0] r, input logic e,
                                input logic h, input logic dn);
        vec_t v;
        v.addr = a; v.len = l; v.d = d; v.csum = c;
        v.exp_resp = r; v.exp_err = e; v.exp_hold = h; v.exp_done = dn;
        return v;
    endfunction

    initial begin
        bit         seen;
        logic [7:0] r;
        logic [7:0] a, l, c, j;
        bit         good;

        tbl[0] = mk(8'h10, 8'h03, 32'h00332211, 8'h79, 8'h06, 1'b0, 1'b0, 1'b1);
        tbl[1] = mk(8'h10, 8'h03, 32'h00332211, 8'h78, 8'h15, 1'b1, 1'b1, 1'b0);
        tbl[2] = mk(8'h10, 8'h03, 32'h00332211, 8'h79, 8'h06, 1'b0, 1'b0, 1'b1);
        tbl[3] = mk(8'hFE, 8'h02, 32'h0000BBAA, 8'h4B, 8'h15, 1'b1, 1'b1, 1'b0);
        tbl[4] = mk(8'hFE, 8'h02, 32'h0000BBAA, 8'h65, 8'h06, 1'b0, 1'b0, 1'b1);
        tbl[5] = mk(8'h00, 8'h01, 32'h000000A5, 8'hA6, 8'h06, 1'b0, 1'b0, 1'b1);
        tbl[6] = mk(8'h7F, 8'h04, 32'h04030201, 8'h8D, 8'h06, 1'b0, 1'b0, 1'b1);

        reset    = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_busy  = 1'b0;
        idle(3);
        check_reset_outputs("reset");
        reset = 1'b0;
        idle(2);

        // Cycle-exact frame: hold rise, write timing, response timing.
        wq.delete();
        txq.delete();
        drive(8'hA5);
        check("hold_rise", 32'(cpu_hold), 32'h1);
        drive(8'h10);
        drive(8'h01);
        drive(8'h5A);
        check("we_n1",    32'(mem_we),    32'h1);
        check("addr_n1",  32'(mem_addr),  32'h10);
        check("wdata_n1", 32'(mem_wdata), 32'h5A);
        idle(1);
        check("we_width",   32'(mem_we),    32'h0);
        check("addr_hold",  32'(mem_addr),  32'h10);
        check("wdata_hold", 32'(mem_wdata), 32'h5A);
        drive(8'h6B);
        check("resp_data", 32'(tx_data),  32'h06);
        check("resp_wait", 32'(tx_start), 32'h0);
        idle(1);
        check("tx_start_pulse",  32'(tx_start),  32'h1);
        check("load_done_pulse", 32'(load_done), 32'h1);
        check("hold_fall",       32'(cpu_hold),  32'h0);
        idle(1);
        check("tx_start_width",  32'(tx_start),  32'h0);
        check("load_done_width", 32'(load_done), 32'h0);
        check("tx_data_stable",  32'(tx_data),   32'h06);
        check("tx_count",        32'(txq.size()), 32'h1);

        // Fixed frames from the table.
        for (int i = 0; i < 7; i++) begin
            pl_q.delete();
            for (int k = 0; k < int'(tbl[i].len); k++) pl_q.push_back(tbl[i].d[k]);
            run_frame($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].len, tbl[i].csum, 0,
                      tbl[i].exp_resp, tbl[i].exp_err, tbl[i].exp_hold, int'(tbl[i].exp_done));
        end

        // Transmitter busy for 20 cycles at frame end; a byte in RESP is dropped.
        wq.delete();
        txq.delete();
        tx_busy = 1'b1;
        drive(8'hA5);
        drive(8'h20);
        drive(8'h02);
        drive(8'h01);
        drive(8'h02);
        drive(8'h25);
        seen = tx_start;
        drive(8'hA5);
        seen = seen | tx_start;
        for (int i = 0; i < 18; i++) begin
            idle(1);
            seen = seen | tx_start;
        end
        check("busy_no_start", 32'(seen), 32'h0);
        tx_busy = 1'b0;
        idle(1);
        check("busy_start",     32'(tx_start),  32'h1);
        check("busy_load_done", 32'(load_done), 32'h1);
        idle(1);
        check("busy_start_width", 32'(tx_start), 32'h0);
        idle(3);
        check("busy_tx_count", 32'(txq.size()), 32'h1);
        check("resp_drop_hold", 32'(cpu_hold),  32'h0);
        check("busy_nwrites",   32'(wq.size()), 32'h2);

        // Timeout after ADDR: fires exactly TMO cycles after the last byte.
        wq.delete();
        txq.delete();
        drive(8'hA5);
        drive(8'h30);
        idle(TMO - 1);
        check("tmo_early_err", 32'(err), 32'h0);
        idle(1);
        check("tmo_err",       32'(err),        32'h1);
        check("tmo_hold",      32'(cpu_hold),   32'h1);
        check("tmo_no_tx",     32'(txq.size()), 32'h0);
        drive(8'h00);
        drive(8'hFF);
        idle(2);
        check("junk_err",     32'(err),       32'h1);
        check("junk_nwrites", 32'(wq.size()), 32'h0);
        pl_q = '{8'h01, 8'h02};
        run_frame("after_tmo", 8'h40, 8'h02, 8'h45, 0, 8'h06, 1'b0, 1'b0, 1);

        // A byte arriving in the expiry cycle wins over the timeout.
        txq.delete();
        drive(8'hA5);
        drive(8'h50);
        idle(TMO - 1);
        drive(8'h01);
        check("tmo_byte_wins", 32'(err), 32'h0);
        drive(8'h7E);
        drive(8'hCF);
        wait_resp("tmo_edge", r);
        check("tmo_edge resp", 32'(r), 32'h06);

        // LEN = 0: 256 bytes across the whole address space.
        pl_q.delete();
        for (int i = 0; i < 256; i++) pl_q.push_back(8'($urandom));
        run_frame("len0", 8'h00, 8'h00, model_sum(8'h00, 8'h00), 0, 8'h06, 1'b0, 1'b0, 1);

        // Random frames against the model, with junk in IDLE and byte gaps.
        for (int f = 0; f < 30; f++) begin
            j = 8'($urandom);
            if (j == 8'hA5) j = 8'h5A;
            drive(j);
            idle(1);
            a = 8'($urandom);
            l = 8'($urandom_range(1, 12));
            pl_q.delete();
            for (int i = 0; i < int'(l); i++) pl_q.push_back(8'($urandom));
            good = ($urandom_range(0, 3) != 0);
            c = model_sum(a, l);
            if (!good) c = c ^ 8'($urandom_range(1, 255));
            run_frame($sformatf("rnd%0d", f), a, l, c, 3,
                      good ? 8'h06 : 8'h15, !good, !good, good ? 1 : 0);
        end

        // Reset in the middle of the payload.
        drive(8'hA5);
        drive(8'h40);
        drive(8'h08);
        drive(8'h01);
        drive(8'h02);
        drive(8'h03);
        reset = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        reset = 1'b0;
        idle(2);
        pl_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
        run_frame("post_reset", 8'h40, 8'h08, model_sum(8'h40, 8'h08), 1, 8'h06, 1'b0, 1'b0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_prog_loader.md
# uart_prog_loader

Frame-based program loader sitting directly downstream of the UART receiver and upstream of the computer's memory write port. Parses framed bytes (header, start address, length, payload, checksum) and streams payload bytes into memory. Holds the CPU stopped while a load is in progress. Answers each completed frame with an ACK/NAK byte through the UART transmitter.

## Interface
Parameters:
- ADDR_W, 8, memory address width; addresses wrap modulo 2^ADDR_W
- TIMEOUT_CYCLES, 2700000, inter-byte timeout in clk cycles (100 ms at 27 MHz); must be ≥ 2

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- rx_data  in  8  received byte from UART receiver
- rx_valid  in  1  one-cycle strobe, rx_data valid
- tx_data  out  8  response byte to UART transmitter
- tx_start  out  1  one-cycle strobe requesting transmission of tx_data
- tx_busy  in  1  transmitter busy; tx_start only issued while low
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  8  write data
- mem_we  out  1  one-cycle write strobe
- cpu_hold  out  1  high = CPU must be held stopped
- load_done  out  1  one-cycle pulse on successful frame
- err  out  1  sticky error flag (bad checksum or timeout)

## Operation
- Frame: 0xA5, ADDR, LEN, LEN payload bytes, CSUM. LEN=0 means 256 bytes.
- CSUM = (ADDR + LEN + sum of payload) mod 256. The header byte is excluded.
- FSM states: IDLE, ADDR, LEN, DATA, CSUM, RESP.
- IDLE: a 0xA5 byte moves to ADDR. On entry to ADDR: cpu_hold←1, err←0. Any other byte is ignored.
- ADDR: the byte is latched as the write pointer and added to the running sum; go to LEN.
- LEN: the byte loads the remaining-byte counter (9 bits, 0→256) and is added to the sum; go to DATA.
- DATA: each byte is written to the current pointer. Then the pointer increments modulo 2^ADDR_W, the counter decrements, and the byte is added to the sum. Go to CSUM when the counter reaches 0.
- CSUM: compare the received byte with the sum.
  - Match: tx_data←0x06 (ACK), mark success.
  - Mismatch: tx_data←0x15 (NAK), err←1.
  - Either case: go to RESP.
- RESP: wait for tx_busy=0, then pulse tx_start. On success, also pulse load_done and drop cpu_hold. Go to IDLE.
  - On NAK, cpu_hold stays 1 until a later frame succeeds or reset. A corrupted program never runs.
  - rx_valid bytes arriving in RESP are dropped.
- Timeout: in ADDR/LEN/DATA/CSUM, a counter clears on each rx_valid and increments otherwise. On reaching TIMEOUT_CYCLES: err←1, return to IDLE, no response byte, cpu_hold stays 1.
  - Bytes already written are not rolled back.
- A 0xA5 byte inside a frame is treated as ordinary data; there is no resynchronisation mid-frame.

## Timing
- Reset values: state IDLE; tx_data 0x00; tx_start 0; mem_addr 0; mem_wdata 0; mem_we 0; cpu_hold 0; load_done 0; err 0; sum 0; counters 0.
- Reset mid-frame aborts immediately and releases cpu_hold. No response is sent.
- All outputs are registered.
- Memory writes:
  - rx_valid for a DATA byte in cycle N → mem_we=1 in cycle N+1, with mem_addr/mem_wdata valid in the same cycle.
  - mem_we is exactly one cycle wide.
  - mem_addr/mem_wdata hold their values until the next write.
- cpu_hold rises in the cycle after the header's rx_valid.
- Checksum byte's rx_valid in cycle N → RESP from N+1. tx_start is asserted in the first cycle ≥ N+1 with tx_busy=0 sampled low.
  - load_done and the cpu_hold fall (successful frame) register in that same cycle as tx_start.
  - tx_data is stable from N+1 until the next response.
- Back-to-back rx_valid on consecutive cycles must be accepted with no loss in any state other than RESP.
- Timeout fires exactly TIMEOUT_CYCLES cycles after the last accepted byte.
- A simultaneous rx_valid in the timeout-expiry cycle: the byte wins and the counter clears.

## Test plan
- Frame A5 10 03 11 22 33 CSUM=0x79:
  - Writes 0x11@0x10, 0x22@0x11, 0x33@0x12, each a one-cycle mem_we.
  - ACK 0x06 sent; load_done pulses once; cpu_hold 1→0; err=0.
- Same frame with CSUM=0x78 → three writes occur, NAK 0x15 sent, err=1, cpu_hold stays 1. A following good frame clears err and drops cpu_hold.
- Wrap and LEN=0:
  - A5 FE 02 AA BB 4B → writes at 0xFE, 0xFF.
  - A5 00 00 + 256 bytes → 256 writes covering 0x00–0xFF, then ACK.
- Header then ADDR, then silence for TIMEOUT_CYCLES (set to 50 in the bench) → err=1 at cycle 50, state IDLE, no tx_start, cpu_hold=1. Junk bytes 0x00, 0xFF in IDLE → ignored.
- tx_busy held high 20 cycles at frame end → tx_start issued in the first cycle after tx_busy falls, exactly once.
- Assert reset mid-payload → all outputs return to reset values immediately. A subsequent full frame loads correctly.
